// File: rtl/event_stats_collector.sv
// Collects per-window timestamp statistics from the event logger and, when the
// window's count beat arrives, emits a fixed 5-beat AXI-Stream report.
module event_stats_collector #(
   parameter logic [15:0] OUT_TDEST = 16'h0000,
   parameter logic [15:0] OUT_TID   = 16'h0000
) (
   input  logic        clk,
   input  logic        aresetn,
   input  logic [63:0] ts_TDATA,
   input  logic [7:0]  ts_TKEEP,
   input  logic        ts_TLAST,
   input  logic        ts_TVALID,
   output logic        ts_TREADY,
   input  logic [63:0] cnt_TDATA,
   input  logic [7:0]  cnt_TKEEP,
   input  logic        cnt_TLAST,
   input  logic        cnt_TVALID,
   output logic        cnt_TREADY,
   output logic [63:0] report_TDATA,
   output logic [7:0]  report_TKEEP,
   output logic [15:0] report_TDEST,
   output logic [15:0] report_TID,
   output logic        report_TVALID,
   input  logic        report_TREADY,
   output logic        report_TLAST,
   output logic        count_mismatch
);

   typedef enum logic {
      COLLECT,
      REPORT
   } state_t;

   localparam logic [2:0]  LAST_BEAT = 3'd4;
   localparam logic [63:0] ALL_ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

   state_t      state;
   state_t      state_next;
   logic [2:0]  beat_idx;

   logic [63:0] ts_count;
   logic [63:0] prev_ts;
   logic        have_prev;
   logic [63:0] min_d;
   logic [63:0] max_d;
   logic [63:0] sum_d;
   logic [63:0] log_cnt;

   logic        ts_fire;
   logic        cnt_fire;
   logic        rpt_fire;
   logic        report_done;

   logic [63:0] delta;
   logic [64:0] sum_ext;
   logic [63:0] ts_count_inc;
   logic [63:0] ts_count_after;
   logic [63:0] next_beat_word;
   logic [2:0]  beat_idx_inc;

   logic        unused_inputs;
   assign unused_inputs = ^{ts_TKEEP, ts_TLAST, cnt_TKEEP, cnt_TLAST};

   assign report_TDEST = OUT_TDEST;
   assign report_TID   = OUT_TID;

   assign ts_fire     = ts_TVALID & ts_TREADY;
   assign cnt_fire    = cnt_TVALID & cnt_TREADY;
   assign rpt_fire    = report_TVALID & report_TREADY;
   assign report_done = (state == REPORT) && rpt_fire && (beat_idx == LAST_BEAT);

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state <= COLLECT;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         COLLECT: if (cnt_fire)    state_next = REPORT;
         REPORT:  if (report_done) state_next = COLLECT;
         default:                  state_next = COLLECT;
      endcase
   end

   // Ready decodes state only, so no input can ripple through to upstream.
   always_comb begin
      ts_TREADY  = 1'b0;
      cnt_TREADY = 1'b0;
      if (state == COLLECT) begin
         ts_TREADY  = 1'b1;
         cnt_TREADY = 1'b1;
      end
   end

   // Modular subtraction keeps deltas correct across timestamp wrap-around.
   always_comb begin
      delta          = ts_TDATA - prev_ts;
      sum_ext        = {1'b0, sum_d} + {1'b0, delta};
      ts_count_inc   = (&ts_count) ? ts_count : ts_count + 64'd1;
      ts_count_after = ts_fire ? ts_count_inc : ts_count;
      beat_idx_inc   = beat_idx + 3'd1;
   end

   always_comb begin
      next_beat_word = log_cnt;
      case (beat_idx_inc)
         3'd1:    next_beat_word = ts_count;
         3'd2:    next_beat_word = min_d;
         3'd3:    next_beat_word = max_d;
         3'd4:    next_beat_word = sum_d;
         default: next_beat_word = log_cnt;
      endcase
   end

   // Stats are frozen during REPORT because ts_TREADY is low there.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         ts_count  <= '0;
         prev_ts   <= '0;
         have_prev <= 1'b0;
         min_d     <= ALL_ONES;
         max_d     <= '0;
         sum_d     <= '0;
      end else if (ts_fire) begin
         ts_count  <= ts_count_inc;
         prev_ts   <= ts_TDATA;
         have_prev <= 1'b1;
         if (have_prev) begin
            if (delta < min_d) min_d <= delta;
            if (delta > max_d) max_d <= delta;
            sum_d <= sum_ext[64] ? ALL_ONES : sum_ext[63:0];
         end
      end else if (report_done) begin
         ts_count  <= '0;
         have_prev <= 1'b0;
         min_d     <= ALL_ONES;
         max_d     <= '0;
         sum_d     <= '0;
      end
   end

   // The count comparison includes a timestamp accepted in the same cycle.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         log_cnt        <= '0;
         count_mismatch <= 1'b0;
      end else if (cnt_fire) begin
         log_cnt        <= cnt_TDATA;
         count_mismatch <= (cnt_TDATA != ts_count_after);
      end
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         beat_idx      <= '0;
         report_TVALID <= 1'b0;
         report_TDATA  <= '0;
         report_TKEEP  <= '0;
         report_TLAST  <= 1'b0;
      end else if (cnt_fire) begin
         beat_idx      <= '0;
         report_TVALID <= 1'b1;
         report_TDATA  <= cnt_TDATA;
         report_TKEEP  <= 8'hFF;
         report_TLAST  <= 1'b0;
      end else if (state == REPORT && rpt_fire) begin
         if (beat_idx == LAST_BEAT) begin
            beat_idx      <= '0;
            report_TVALID <= 1'b0;
            report_TDATA  <= '0;
            report_TKEEP  <= '0;
            report_TLAST  <= 1'b0;
         end else begin
            beat_idx     <= beat_idx_inc;
            report_TDATA <= next_beat_word;
            report_TLAST <= (beat_idx_inc == LAST_BEAT);
         end
      end
   end

endmodule
